alu_word_sequencer: RTL

//  Multi-cycle controller that runs WORDS*SIZE-bit operations on the SIZE-bit ALU, one SIZE-bit slice per cycle.
//  It feeds each slice's carry into the next slice.

---
 rtl/alu_word_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs SIZE*WORDS-bit ops on a SIZE-bit ALU one slice per cycle, chaining carry.
// Define ALU_SEQ_FLAGS_EN to add the registered o_rsp_zero/o_rsp_neg result flags.
module alu_word_sequencer #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [2:0]            i_req_op,
    input  logic [SIZE*WORDS-1:0] i_req_a,
    input  logic [SIZE*WORDS-1:0] i_req_b,
    input  logic                  i_req_cin,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [SIZE*WORDS-1:0] o_rsp_result,
    output logic                  o_rsp_carry,
    output logic                  o_alu_ce,
    output logic [2:0]            o_alu_op,
    output logic [SIZE-1:0]       o_alu_left,
    output logic [SIZE-1:0]       o_alu_right,
    output logic                  o_alu_cin,
    input  logic                  i_alu_cout,
    input  logic [SIZE-1:0]       i_alu_out,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                  o_rsp_zero,
    output logic                  o_rsp_neg,
`endif
    output logic                  o_busy
);
    localparam int W  = SIZE * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_res;
    logic            r_c;
    logic            r_rsp_valid;
    logic [W-1:0]    w_res;
    logic [SIZE-1:0] w_b;
    logic            w_exec;
    logic            w_last;
    logic            w_arith;
`ifdef ALU_SEQ_FLAGS_EN
    logic            r_zero;
    logic            r_neg;
    assign o_rsp_zero = r_zero;
    assign o_rsp_neg  = r_neg;
`endif
    assign w_exec  = r_state == EXEC;
    assign w_last  = r_idx == IW'(WORDS - 1);
    assign w_arith = r_op == OP_ADD || r_op == OP_SUB;
    assign w_b     = r_b[SIZE*r_idx +: SIZE];
    always_comb begin
        w_res                      = r_res;
        w_res[SIZE*r_idx +: SIZE]  = i_alu_out;
    end
    assign o_req_ready  = r_state == IDLE;
    assign o_busy       = r_state != IDLE;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_res;
    assign o_rsp_carry  = r_c;
    assign o_alu_ce     = w_exec;
    assign o_alu_op     = w_exec ? (r_op == OP_SUB ? OP_ADD : r_op) : 3'd0;
    assign o_alu_left   = w_exec ? r_a[SIZE*r_idx +: SIZE] : '0;
    assign o_alu_right  = w_exec ? (r_op == OP_SUB ? ~w_b : w_b) : '0;
    assign o_alu_cin    = w_exec & r_c;
    // r_c holds the slice carry-in during EXEC and the final carry once in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_c         <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else if (r_state == IDLE) begin
            if (i_req_valid) begin
                r_op    <= i_req_op;
                r_a     <= i_req_a;
                r_b     <= i_req_b;
                r_c     <= (i_req_op == OP_ADD && i_req_cin) || i_req_op == OP_SUB;
                r_idx   <= '0;
                r_state <= EXEC;
            end
        end else if (w_exec) begin
            r_res <= w_res;
            r_c   <= w_arith & i_alu_cout;
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
                r_state     <= DONE;
                r_rsp_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                r_zero      <= w_res == '0;
                r_neg       <= w_res[W-1];
`endif
            end
        end else if (i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
        end
    end
endmodule
